// File: rtl/tsbus_pkg.sv
// Shared types and defaults for the tri-state bus arbiter.
// Parking variant selected by TRISTATE_BUS_PARK_EN.
package tsbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_MAX_BURST = 8;
    localparam int CNT_W         = 8;

endpackage

// File: rtl/tsbus_rr_pick.sv
// Round-robin winner search starting at a given index, wrapping.
// Lowest offset from start with an active request wins.
module tsbus_rr_pick
    import tsbus_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] start,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     valid
);

    localparam int OW = $clog2(N_REQ);

    int idx;

    // Walk offsets high to low so the nearest requester is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % N_REQ;
            if (req[idx]) begin
                winner = OW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus with turnaround gap.
// Define TRISTATE_BUS_PARK_EN to park the bus on the last owner while idle.
module tristate_bus_arbiter
    import tsbus_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         en_n,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy
);

    localparam int OW = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [OW-1:0]    owner_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OW-1:0]    rr_start, pick_idx;
    logic             pick_valid;
    logic [N_REQ-1:0] gnt_d, en_n_d, onehot;
    logic             busy_d;

    assign rr_start = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    tsbus_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .start  (rr_start),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner   <= OW'(N_REQ - 1);
            count_q <= '0;
            gnt     <= '0;
            en_n    <= '1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner   <= owner_d;
            count_q <= count_d;
            gnt     <= gnt_d;
            en_n    <= en_n_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
`ifdef TRISTATE_BUS_PARK_EN
                // Parked owner already drives; anyone else needs a gap first.
                if (req[owner]) begin
                    state_d = OWN;
                    count_d = 8'd1;
                end else if (pick_valid) begin
                    state_d = TURN;
                end
`else
                if (pick_valid) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                    count_d = 8'd1;
                end
`endif
            end
            OWN: begin
                if (req[owner] && (count_q < CNT_W'(MAX_BURST))) begin
                    count_d = count_q + 8'd1;
                end else begin
                    state_d = TURN;
                    count_d = '0;
                end
            end
            TURN: begin
                if (pick_valid) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                    count_d = 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d           = '0;
        en_n_d          = '1;
        busy_d          = (state_d != IDLE);
        onehot          = '0;
        onehot[owner_d] = 1'b1;
        unique case (state_d)
            OWN: begin
                gnt_d  = onehot;
                en_n_d = ~onehot;
            end
            IDLE: begin
`ifdef TRISTATE_BUS_PARK_EN
                en_n_d = ~onehot;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter (N_REQ=4, MAX_BURST=8).
// Stimulus queues expected outputs; a monitor compares after each edge.
module tb_tristate_bus_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] en_n;
        logic [1:0] owner;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt, en_n;
    logic [1:0] owner;
    logic       busy;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_step = 0;

    tristate_bus_arbiter #(.N_REQ(4), .MAX_BURST(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .en_n  (en_n),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t own(input int w);
        exp_t e;
        e.gnt   = 4'(1 << w);
        e.en_n  = ~e.gnt;
        e.owner = 2'(w);
        e.busy  = 1'b1;
        return e;
    endfunction

    function automatic exp_t turn(input int o);
        exp_t e;
        e.gnt   = 4'b0000;
        e.en_n  = 4'b1111;
        e.owner = 2'(o);
        e.busy  = 1'b1;
        return e;
    endfunction

    function automatic exp_t idle(input int o);
        exp_t e;
        e.gnt   = 4'b0000;
`ifdef TRISTATE_BUS_PARK_EN
        e.en_n  = ~(4'(1 << o));
`else
        e.en_n  = 4'b1111;
`endif
        e.owner = 2'(o);
        e.busy  = 1'b0;
        return e;
    endfunction

    task automatic step(input logic [3:0] r, input exp_t e);
        @(negedge clk);
        req = r;
        exp_q.push_back(e);
    endtask

    // Reset is asserted between edges and checked before any clock arrives.
    task automatic do_reset(input string tag);
        exp_t a;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        a = {gnt, en_n, owner, busy};
        n_total++;
        if (a === {4'b0000, 4'b1111, 2'd3, 1'b0}) n_pass++;
        else $display("FAIL reset_%s: got %b want %b", tag, a,
                      {4'b0000, 4'b1111, 2'd3, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            n_step++;
            n_total++;
            if ({gnt, en_n, owner, busy} === e_mon) n_pass++;
            else $display("FAIL step%0d: gnt=%b en_n=%b owner=%0d busy=%b want gnt=%b en_n=%b owner=%0d busy=%b",
                          n_step, gnt, en_n, owner, busy,
                          e_mon.gnt, e_mon.en_n, e_mon.owner, e_mon.busy);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want done");
        $fatal(1);
    end

    initial begin
        do_reset("init");
`ifdef TRISTATE_BUS_PARK_EN
        step(4'b0000, idle(3));
        step(4'b0001, turn(3));
        step(4'b0001, own(0));
        step(4'b0010, turn(0));
        step(4'b0010, own(1));
        step(4'b0000, turn(1));
        step(4'b0000, idle(1));
        step(4'b0010, own(1));
        step(4'b0000, turn(1));
        step(4'b0000, idle(1));
        step(4'b0001, turn(1));
        step(4'b0001, own(0));
        step(4'b0000, turn(0));
        step(4'b0000, idle(0));
`else
        // Short single burst from reset.
        for (int i = 0; i < 3; i++) step(4'b0001, own(0));
        step(4'b0000, turn(0));
        step(4'b0000, idle(0));
        step(4'b0000, idle(0));

        // All requesting: full bursts rotate 0,1,2,3,0.
        do_reset("rr");
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) step(4'b1111, own(k % 4));
            step(4'b1111, turn(k % 4));
        end
        step(4'b0000, idle(0));

        // Sole requester: 8 on, 1 gap, repeat.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) step(4'b0010, own(1));
            step(4'b0010, turn(1));
        end
        step(4'b0000, idle(1));

        // Owner 0 ignores other requests, then drops while 3 waits.
        step(4'b0001, own(0));
        step(4'b0101, own(0));
        step(4'b1011, own(0));
        step(4'b1000, turn(0));
        step(4'b1000, own(3));
        step(4'b0000, turn(3));
        step(4'b0000, idle(3));

        // Reset mid-burst on owner 2, then regrant from reset owner.
        step(4'b0100, own(2));
        step(4'b0100, own(2));
        do_reset("midown");
        step(4'b0100, own(2));
        step(4'b0000, turn(2));
        step(4'b0000, idle(2));
`endif
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one tri-state bus (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum consecutive ownership cycles (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req  input  N_REQ  per-requester bus request, level-sensitive.
REQ-006 SHALL have port gnt  output  N_REQ  per-requester grant, one-hot or all-zero.
REQ-007 SHALL have port en_n  output  N_REQ  active-low tri-state enable per buffer (low = drive, high = Z).
REQ-008 SHALL have port owner  output  $clog2(N_REQ)  index of current or last owner.
REQ-009 SHALL have port busy  output  1  high in OWN or TURN.

Function
REQ-010 SHALL implement FSM states IDLE, OWN, TURN; all outputs registered.
REQ-011 IDLE: no req -> stay; any req -> OWN next cycle, winner chosen round-robin.
REQ-012 Round-robin SHALL search from index owner+1 mod N_REQ upward, wrapping.
REQ-013 On OWN entry, gnt[w] and en_n[w]=0 SHALL assert in the same cycle; owner=w.
REQ-014 OWN SHALL count ownership cycles from 1; stay while req[owner]=1 and count<MAX_BURST.
REQ-015 OWN -> TURN when req[owner]=0 or count==MAX_BURST, whichever first.
REQ-016 TURN SHALL last exactly 1 cycle with all en_n=1, gnt=0 (no bus contention).
REQ-017 TURN -> OWN if any req (round-robin winner), else IDLE.
REQ-018 A sole requester held high SHALL regain the bus after each TURN (MAX_BURST on, 1 off).
REQ-019 SHALL guarantee at most one en_n bit low in every cycle.
REQ-020 Changes on req of non-owners during OWN SHALL not affect the current owner.
REQ-021 SHALL always hold gnt == ~en_n, except when parking per REQ-027.

Reset
REQ-022 On rst_n=0, all en_n SHALL go high and gnt=0 immediately, without waiting for clk.
REQ-023 Reset values: state=IDLE, owner=N_REQ-1 (index 0 wins first), count=0, busy=0.
REQ-024 Reset mid-OWN SHALL abort the burst; first grant after release follows REQ-011.

Configuration
REQ-025 Macro TRISTATE_BUS_PARK_EN SHALL select bus parking.
REQ-026 Without the macro, IDLE SHALL drive all en_n=1 (bus floats Z).
REQ-027 With the macro, IDLE SHALL hold en_n[owner]=0 with gnt=0 (park); after reset the park owner is N_REQ-1.
REQ-028 With the macro, a req from the park owner in IDLE SHALL go to OWN directly, with no TURN.
REQ-029 With the macro, a req from any other index in IDLE SHALL pass through TURN first.

Structure
REQ-030 Package tsbus_pkg SHALL hold the state enum (IDLE, OWN, TURN) and the default N_REQ/MAX_BURST constants.
REQ-031 Sub-module tsbus_rr_pick SHALL compute the winner index and a valid flag from req and the start index.
REQ-032 Burst counter width SHALL be 8 bits; compare with MAX_BURST only, no wrap.

Verification
REQ-033 Reset, then req=4'b0001 held 3 cycles -> gnt=0001 and en_n=1110 on cycle+1 for 3 cycles, then TURN, then IDLE.
REQ-034 req=4'b1111 held, MAX_BURST=8 -> owners 0,1,2,3,0 each for 8 cycles, with a 1-cycle all-Z gap between them.
REQ-035 req=0010 held -> owner 1 gets 8 on, 1 TURN, and repeats; en_n is never low on 2 bits.
REQ-036 Owner 2 in OWN, assert rst_n=0 between edges -> en_n=1111 at once; after release with req=0100, grant 2 follows REQ-011.
REQ-037 Owner 0 drops req while req[3]=1 -> TURN 1 cycle, then gnt=1000.
REQ-038 With TRISTATE_BUS_PARK_EN: idle after owner 1 -> en_n=1101, gnt=0; req=0010 -> OWN next cycle; req=0001 -> TURN, then OWN on 0.
